// File: rtl/sobel_edge_detector.sv
// 3x3 Sobel gradient magnitude over a raster-read frame, written back as a luma-only edge frame.
// Optional SOBEL_BORDER_CLEAR_EN adds a fifth phase per pixel that writes 0 to border pixels.
//
//   state | meaning
//   IDLE  | waiting for start, outputs hold
//   RUN   | stepping pixel slots P0..P3 (P4 with border clear)
module sobel_edge_detector #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        done,
   output logic        busy,
   output logic [18:0] read_addr,
   input  logic [35:0] read_data,
   output logic [18:0] write_addr,
   output logic [35:0] write_data,
   output logic        write_enable
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
   localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);
   localparam logic [19:0] CHROMA = {10'd512, 10'd512};

   state_t      state_q, state_d;
   logic [2:0]  phase_q, phase_d;
   logic [9:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic [18:0] read_addr_q, read_addr_d;
   logic [18:0] write_addr_q, write_addr_d;
   logic [35:0] write_data_q, write_data_d;
   logic        write_enable_q, write_enable_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic [9:0]  win_q [3][3];
   logic [9:0]  win_d [3][3];
   logic [9:0]  win_n [3][3];
   logic [9:0]  lb0_q [WIDTH];
   logic [9:0]  lb1_q [WIDTH];
   logic        lb_we;
   logic [9:0]  pix;
   logic [XW-1:0] xi;
   logic [12:0] gx_p, gx_n, gy_p, gy_n, gx_u, gy_u, ax, ay;
   logic [13:0] mag;
   logic [9:0]  edge_val;
   logic        unused_rd;
`ifdef SOBEL_BORDER_CLEAR_EN
   logic [9:0]  bx_q, bx_d;
   logic [8:0]  by_q, by_d;
`endif

   assign pix       = read_data[29:20];
   assign unused_rd = ^{read_data[35:30], read_data[19:0]};
   assign xi        = x_q[XW-1:0];

   // Window as it will look after this slot's shift; the write uses it directly.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_n[r][0] = win_q[r][1];
         win_n[r][1] = win_q[r][2];
      end
      win_n[0][2] = lb1_q[xi];
      win_n[1][2] = lb0_q[xi];
      win_n[2][2] = pix;

      gx_p = {3'b0, win_n[0][2]} + {2'b0, win_n[1][2], 1'b0} + {3'b0, win_n[2][2]};
      gx_n = {3'b0, win_n[0][0]} + {2'b0, win_n[1][0], 1'b0} + {3'b0, win_n[2][0]};
      gy_p = {3'b0, win_n[2][0]} + {2'b0, win_n[2][1], 1'b0} + {3'b0, win_n[2][2]};
      gy_n = {3'b0, win_n[0][0]} + {2'b0, win_n[0][1], 1'b0} + {3'b0, win_n[0][2]};
      gx_u = gx_p - gx_n;
      gy_u = gy_p - gy_n;
      ax   = gx_u[12] ? (13'd0 - gx_u) : gx_u;
      ay   = gy_u[12] ? (13'd0 - gy_u) : gy_u;
      mag  = {1'b0, ax} + {1'b0, ay};
      edge_val = (mag > 14'd1023) ? 10'd1023 : mag[9:0];
   end

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      x_d            = x_q;
      y_d            = y_q;
      read_addr_d    = read_addr_q;
      write_addr_d   = write_addr_q;
      write_data_d   = write_data_q;
      write_enable_d = 1'b0;
      done_d         = 1'b0;
      busy_d         = busy_q;
      win_d          = win_q;
      lb_we          = 1'b0;
`ifdef SOBEL_BORDER_CLEAR_EN
      bx_d           = bx_q;
      by_d           = by_q;
`endif
      if (start) begin
         state_d = RUN;
         phase_d = 3'd0;
         x_d     = 10'd0;
         y_d     = 9'd0;
         busy_d  = 1'b1;
         win_d   = '{default: '0};
      end else if (state_q == RUN) begin
         case (phase_q)
            3'd0: begin
               read_addr_d = {y_q, x_q};
               phase_d     = 3'd1;
            end
            3'd3: begin
               win_d = win_n;
               lb_we = 1'b1;
               if (x_q >= 10'd2 && y_q >= 9'd2) begin
                  write_addr_d   = {y_q - 9'd1, x_q - 10'd1};
                  write_data_d   = {6'b0, edge_val, CHROMA};
                  write_enable_d = 1'b1;
               end
               if (x_q == X_LAST) begin
                  x_d = 10'd0;
                  y_d = (y_q == Y_LAST) ? 9'd0 : y_q + 9'd1;
               end else begin
                  x_d = x_q + 10'd1;
               end
`ifdef SOBEL_BORDER_CLEAR_EN
               bx_d    = x_q;
               by_d    = y_q;
               phase_d = 3'd4;
`else
               phase_d = 3'd0;
               if (x_q == X_LAST && y_q == Y_LAST) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
`endif
            end
`ifdef SOBEL_BORDER_CLEAR_EN
            3'd4: begin
               if (bx_q == 10'd0 || bx_q == X_LAST || by_q == 9'd0 || by_q == Y_LAST) begin
                  write_addr_d   = {by_q, bx_q};
                  write_data_d   = {6'b0, 10'd0, CHROMA};
                  write_enable_d = 1'b1;
               end
               phase_d = 3'd0;
               if (bx_q == X_LAST && by_q == Y_LAST) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
`endif
            default: phase_d = phase_q + 3'd1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         phase_q        <= 3'd0;
         x_q            <= 10'd0;
         y_q            <= 9'd0;
         read_addr_q    <= '0;
         write_addr_q   <= '0;
         write_data_q   <= '0;
         write_enable_q <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
         win_q          <= '{default: '0};
`ifdef SOBEL_BORDER_CLEAR_EN
         bx_q           <= 10'd0;
         by_q           <= 9'd0;
`endif
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         x_q            <= x_d;
         y_q            <= y_d;
         read_addr_q    <= read_addr_d;
         write_addr_q   <= write_addr_d;
         write_data_q   <= write_data_d;
         write_enable_q <= write_enable_d;
         done_q         <= done_d;
         busy_q         <= busy_d;
         win_q          <= win_d;
`ifdef SOBEL_BORDER_CLEAR_EN
         bx_q           <= bx_d;
         by_q           <= by_d;
`endif
      end
   end

   // Line buffers carry no reset so they can map onto RAM.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         lb1_q[xi] <= lb0_q[xi];
         lb0_q[xi] <= pix;
      end
   end

   assign done         = done_q;
   assign busy         = busy_q;
   assign read_addr    = read_addr_q;
   assign write_addr   = write_addr_q;
   assign write_data   = write_data_q;
   assign write_enable = write_enable_q;
endmodule

// File: tb/tb_sobel_edge_detector.sv
// Scoreboard bench for sobel_edge_detector on an 8x6 frame; honours SOBEL_BORDER_CLEAR_EN.
module tb_sobel_edge_detector;
   localparam int W = 8;
   localparam int H = 6;
`ifdef SOBEL_BORDER_CLEAR_EN
   localparam int PH = 5;
`else
   localparam int PH = 4;
`endif
   localparam int FT = PH * W * H;

   logic        clk, reset, start, done, busy, write_enable;
   logic [18:0] read_addr, write_addr;
   logic [35:0] read_data, write_data;

   typedef struct {
      logic [18:0] a;
      logic [35:0] d;
   } wr_t;
   wr_t sb_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int pattern = 0;
   int done_cnt = 0;
   int wr_cnt = 0;
   bit ignore_wr = 0;

   sobel_edge_detector #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
      .read_addr(read_addr), .read_data(read_data), .write_addr(write_addr),
      .write_data(write_data), .write_enable(write_enable)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic int luma(int x, int y);
      case (pattern)
         1: return (x < 4) ? 0 : 100;
         2: return (y < 3) ? 0 : 1023;
         default: return 300;
      endcase
   endfunction

   always @(posedge clk)
      read_data <= {6'h2a, 10'(luma(int'(read_addr[9:0]), int'(read_addr[18:10]))), 20'h5a5a5};

   function automatic int sob(int cx, int cy);
      int gx, gy, m;
      gx = (luma(cx+1,cy-1) + 2*luma(cx+1,cy) + luma(cx+1,cy+1))
         - (luma(cx-1,cy-1) + 2*luma(cx-1,cy) + luma(cx-1,cy+1));
      gy = (luma(cx-1,cy+1) + 2*luma(cx,cy+1) + luma(cx+1,cy+1))
         - (luma(cx-1,cy-1) + 2*luma(cx,cy-1) + luma(cx+1,cy-1));
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (m > 1023) ? 1023 : m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Writes appear in the order pixels are read: interior centre first, then the border clear.
   task automatic push_frame();
      wr_t e;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            if (x >= 2 && y >= 2) begin
               e.a = {9'(y-1), 10'(x-1)};
               e.d = {6'b0, 10'(sob(x-1, y-1)), 10'd512, 10'd512};
               sb_q.push_back(e);
            end
`ifdef SOBEL_BORDER_CLEAR_EN
            if (x == 0 || x == W-1 || y == 0 || y == H-1) begin
               e.a = {9'(y), 10'(x)};
               e.d = {6'b0, 10'd0, 10'd512, 10'd512};
               sb_q.push_back(e);
            end
`endif
         end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (done) done_cnt++;
      if (write_enable && !ignore_wr) begin
         wr_cnt++;
         if (sb_q.size() > 0) e = sb_q.pop_front();
         else begin
            e.a = '1;
            e.d = '1;
         end
         chk("wr_addr", 64'(write_addr), 64'(e.a));
         chk("wr_data", 64'(write_data), 64'(e.d));
      end
   end

   // Call just after the start edge; checks addressing restart, busy and the done timing.
   task automatic wait_done(input string tag);
      int got_at = -1;
      int d0 = done_cnt;
      for (int k = 1; k <= FT + 4; k++) begin
         @(posedge clk); #1;
         if (k == 1) chk({tag, "_raddr0"}, 64'(read_addr), 64'd0);
         if (k == FT - 1) chk({tag, "_busy_run"}, 64'(busy), 64'd1);
         if (k == FT) chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
         if (done && got_at < 0) got_at = k;
      end
      chk({tag, "_done_edge"}, 64'(got_at), 64'(FT));
      chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
      chk({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
   endtask

   task automatic run_frame(input int p, input string tag);
      @(negedge clk); #1;
      pattern = p;
      push_frame();
      start = 1;
      @(posedge clk); #1;
      start = 0;
      wait_done(tag);
   endtask

   initial begin
      int d0, w0;
      start = 0;
      reset = 1;
      #2 reset = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", 64'(done), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_we", 64'(write_enable), 0);
      chk("rst_raddr", 64'(read_addr), 0);
      chk("rst_waddr", 64'(write_addr), 0);
      chk("rst_wdata", 64'(write_data), 0);
      @(negedge clk) reset = 1;

      w0 = wr_cnt;
      run_frame(0, "flat");
`ifdef SOBEL_BORDER_CLEAR_EN
      chk("flat_wr_cnt", 64'(wr_cnt - w0), 48);
`else
      chk("flat_wr_cnt", 64'(wr_cnt - w0), 24);
`endif
      run_frame(1, "vstep");
      run_frame(2, "hstep");

      // Asynchronous reset mid-frame
      @(negedge clk); #1;
      pattern = 0;
      push_frame();
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (49) @(posedge clk);
      #3 reset = 0;
      #1;
      chk("abort_busy", 64'(busy), 0);
      chk("abort_we", 64'(write_enable), 0);
      chk("abort_raddr", 64'(read_addr), 0);
      chk("abort_waddr", 64'(write_addr), 0);
      chk("abort_wdata", 64'(write_data), 0);
      sb_q.delete();
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - d0), 0);
      chk("abort_idle_busy", 64'(busy), 0);
      run_frame(1, "after_rst");

      // start re-pulsed mid-frame
      @(negedge clk); #1;
      pattern = 1;
      push_frame();
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (99) @(posedge clk);
      @(negedge clk); #1;
      sb_q.delete();
      push_frame();
      start = 1;
      @(posedge clk); #1;
      start = 0;
      wait_done("restart");

      // start coinciding with the end-of-frame edge: start wins, no done pulse
      @(negedge clk); #1;
      pattern = 2;
      push_frame();
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (FT - 1) @(posedge clk);
      @(negedge clk); #1;
      chk("coll_sb_left", 64'(sb_q.size()), 1);
      sb_q.delete();
      d0 = done_cnt;
      pattern = 0;
      push_frame();
      ignore_wr = 1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      chk("coll_busy", 64'(busy), 1);
      @(negedge clk); #1;
      ignore_wr = 0;
      wait_done("coll");
      chk("coll_done_total", 64'(done_cnt - d0), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
